// File: rtl/ibex_hpm_counter_ctrl_pkg.sv
// Shared CSR numbers and widths for the HPM counter controller.
package ibex_hpm_counter_ctrl_pkg;

  localparam int unsigned CsrAddrW  = 12;
  localparam int unsigned CsrDataW  = 32;
  localparam int unsigned CntSliceW = 64;

  typedef enum logic [CsrAddrW-1:0] {
    CSR_MCOUNTINHIBIT = 12'h320,
    CSR_MHPMEVENT3    = 12'h323,
    CSR_MHPMCOUNTER3  = 12'hB03,
    CSR_MHPMCOUNTER3H = 12'hB83
  } csr_num_e;

endpackage

// File: rtl/ibex_hpm_counter_ctrl_if.sv
// CSR request/response bus between the CSR file and the HPM controller.
interface ibex_hpm_counter_ctrl_if;
  import ibex_hpm_counter_ctrl_pkg::*;

  logic                csr_req_i;
  logic                csr_we_i;
  logic [CsrAddrW-1:0] csr_addr_i;
  logic [CsrDataW-1:0] csr_wdata_i;
  logic                csr_rvalid_o;
  logic [CsrDataW-1:0] csr_rdata_o;
  logic                csr_err_o;

  modport master (
    output csr_req_i, csr_we_i, csr_addr_i, csr_wdata_i,
    input  csr_rvalid_o, csr_rdata_o, csr_err_o
  );

  modport slave (
    input  csr_req_i, csr_we_i, csr_addr_i, csr_wdata_i,
    output csr_rvalid_o, csr_rdata_o, csr_err_o
  );
endinterface

// File: rtl/ibex_hpm_counter_ctrl.sv
// Sequences a bank of HPM counters: CSR decode, event selectors, inhibit,
// increment strobes and sticky overflow flags.
module ibex_hpm_counter_ctrl
  import ibex_hpm_counter_ctrl_pkg::*;
#(
  parameter int unsigned NumCounters  = 4,
  parameter int unsigned NumEvents    = 16,
  parameter int unsigned CounterWidth = 40
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  ibex_hpm_counter_ctrl_if.slave         csr_bus,
  input  logic [NumEvents-1:0]           events_i,
  input  logic [CntSliceW*NumCounters-1:0] cnt_val_i,
  output logic [NumCounters-1:0]         cnt_inc_o,
  output logic [NumCounters-1:0]         cnt_we_o,
  output logic [NumCounters-1:0]         cnth_we_o,
  output logic [CsrDataW-1:0]            cnt_wdata_o,
  output logic [NumCounters-1:0]         ovf_o
);

  localparam logic [CsrDataW-1:0] InhMask =
    CsrDataW'(((64'(1) << NumCounters) - 64'(1)) << 3);

  logic                   w_req;
  logic                   w_wr;
  logic                   w_sel_inh;
  logic                   w_hit;
  logic [NumCounters-1:0] w_sel_evt;
  logic [NumCounters-1:0] w_sel_lo;
  logic [NumCounters-1:0] w_sel_hi;
  logic [NumEvents-1:0]   w_evt_sel [NumCounters];
  logic [CsrDataW-1:0]    w_rdata;

  logic                   r_rvalid;
  logic [CsrDataW-1:0]    r_rdata;
  logic                   r_err;
  logic [CsrDataW-1:0]    r_inhibit;
  logic [NumEvents-1:0]   r_event;

  assign w_req     = csr_bus.csr_req_i;
  assign w_wr      = w_req & csr_bus.csr_we_i;
  assign w_sel_inh = csr_bus.csr_addr_i == CsrAddrW'(CSR_MCOUNTINHIBIT);
  assign w_hit     = w_sel_inh | (|w_sel_evt) | (|w_sel_lo) | (|w_sel_hi);

  // Read mux; counter halves come straight from the request-cycle values.
  always_comb begin
    w_rdata = '0;
    if (w_sel_inh) w_rdata = r_inhibit;
    for (int unsigned k = 0; k < NumCounters; k++) begin
      if (w_sel_evt[k]) w_rdata = CsrDataW'(w_evt_sel[k]);
      if (w_sel_lo[k])  w_rdata = cnt_val_i[CntSliceW*k +: CsrDataW];
      if (w_sel_hi[k])  w_rdata = cnt_val_i[CntSliceW*k+CsrDataW +: CsrDataW];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_inhibit <= '0;
      r_event   <= '0;
    end else begin
      r_rvalid <= w_req;
      r_rdata  <= w_req ? w_rdata : '0;
      r_err    <= w_req & ~w_hit;
      r_event  <= events_i;
      if (w_wr && w_sel_inh) r_inhibit <= csr_bus.csr_wdata_i & InhMask;
    end
  end

  // Per-counter slice: address match, selector, strobes, overflow.
  for (genvar i = 0; i < NumCounters; i++) begin : g_cnt
    logic [NumEvents-1:0] r_sel;
    logic                 r_ovf;
    logic                 w_wrap;

    assign w_sel_evt[i] = csr_bus.csr_addr_i ==
                          CsrAddrW'(CSR_MHPMEVENT3) + CsrAddrW'(i);
    assign w_sel_lo[i]  = csr_bus.csr_addr_i ==
                          CsrAddrW'(CSR_MHPMCOUNTER3) + CsrAddrW'(i);
    assign w_sel_hi[i]  = csr_bus.csr_addr_i ==
                          CsrAddrW'(CSR_MHPMCOUNTER3H) + CsrAddrW'(i);
    assign w_evt_sel[i] = r_sel;

    assign cnt_we_o[i]  = w_wr & w_sel_lo[i];
    assign cnth_we_o[i] = w_wr & w_sel_hi[i];
    assign cnt_inc_o[i] = (|(r_event & r_sel)) & ~r_inhibit[3+i] &
                          ~(cnt_we_o[i] | cnth_we_o[i]);
    assign w_wrap       = cnt_inc_o[i] & (&cnt_val_i[CntSliceW*i +: CounterWidth]);
    assign ovf_o[i]     = r_ovf;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_sel <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (w_wr && w_sel_evt[i]) r_sel <= csr_bus.csr_wdata_i[NumEvents-1:0];
        if (cnt_we_o[i] || cnth_we_o[i]) r_ovf <= 1'b0;
        else if (w_wrap)                 r_ovf <= 1'b1;
      end
    end
  end

  assign cnt_wdata_o          = csr_bus.csr_wdata_i;
  assign csr_bus.csr_rvalid_o = r_rvalid;
  assign csr_bus.csr_rdata_o  = r_rdata;
  assign csr_bus.csr_err_o    = r_err;

endmodule

// File: tb/tb_ibex_hpm_counter_ctrl.sv
// Randomised and directed checks of the HPM counter controller against a
// behavioural model of the CSR map, event path and overflow flags.
module tb_ibex_hpm_counter_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  events;
  logic [255:0] cnt_val;
  logic [3:0]   cnt_inc, cnt_we, cnth_we, ovf;
  logic [31:0]  cnt_wdata;

  int total = 0;
  int bad   = 0;

  ibex_hpm_counter_ctrl_if bus();

  ibex_hpm_counter_ctrl #(
    .NumCounters(4), .NumEvents(16), .CounterWidth(40)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .csr_bus(bus), .events_i(events),
    .cnt_val_i(cnt_val), .cnt_inc_o(cnt_inc), .cnt_we_o(cnt_we),
    .cnth_we_o(cnth_we), .cnt_wdata_o(cnt_wdata), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [15:0] m_sel [4];
  logic [31:0] m_inh;
  logic [15:0] m_ev;
  logic [3:0]  m_ovf;
  bit          m_rv, m_err;
  logic [31:0] m_rd;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_mapped(input logic [11:0] a);
    return (a == 12'h320) || (a >= 12'h323 && a <= 12'h326) ||
           (a >= 12'hB03 && a <= 12'hB06) || (a >= 12'hB83 && a <= 12'hB86);
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    if (a == 12'h320) return m_inh;
    for (int k = 0; k < 4; k++) begin
      if (a == 12'h323 + k) return {16'h0, m_sel[k]};
      if (a == 12'hB03 + k) return cnt_val[64*k +: 32];
      if (a == 12'hB83 + k) return cnt_val[64*k+32 +: 32];
    end
    return 32'h0;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 4; k++) m_sel[k] = 16'h0;
    m_inh = 0; m_ev = 0; m_ovf = 0; m_rv = 0; m_err = 0; m_rd = 0;
  endtask

  task automatic drive(input bit req, input bit we, input logic [11:0] addr,
                       input logic [31:0] wd, input logic [15:0] ev);
    bus.csr_req_i   = req;
    bus.csr_we_i    = we;
    bus.csr_addr_i  = addr;
    bus.csr_wdata_i = wd;
    events          = ev;
  endtask

  // One clock: drive, compare every output against the model, advance the model.
  task automatic step(input bit req, input bit we, input logic [11:0] addr,
                      input logic [31:0] wd, input logic [15:0] ev);
    logic [3:0]  e_inc, e_we, e_weh;
    bit          n_rv, n_err;
    logic [31:0] n_rd;
    drive(req, we, addr, wd, ev);
    #1;
    e_we = 0; e_weh = 0;
    for (int k = 0; k < 4; k++) begin
      if (req && we && addr == 12'hB03 + k) e_we[k]  = 1'b1;
      if (req && we && addr == 12'hB83 + k) e_weh[k] = 1'b1;
    end
    for (int k = 0; k < 4; k++)
      e_inc[k] = ((m_ev & m_sel[k]) != 0) && !m_inh[3+k] && !e_we[k] && !e_weh[k];
    chk("cnt_inc", 64'(cnt_inc), 64'(e_inc));
    chk("cnt_we", 64'(cnt_we), 64'(e_we));
    chk("cnth_we", 64'(cnth_we), 64'(e_weh));
    chk("cnt_wdata", 64'(cnt_wdata), 64'(wd));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    chk("rvalid", 64'(bus.csr_rvalid_o), 64'(m_rv));
    if (m_rv) begin
      chk("rdata", 64'(bus.csr_rdata_o), 64'(m_rd));
      chk("err", 64'(bus.csr_err_o), 64'(m_err));
    end
    n_rv  = req;
    n_err = req && !m_mapped(addr);
    n_rd  = req ? m_read(addr) : 32'h0;
    @(posedge clk);
    m_rv = n_rv; m_err = n_err; m_rd = n_rd;
    for (int k = 0; k < 4; k++) begin
      if (e_we[k] || e_weh[k]) m_ovf[k] = 1'b0;
      else if (e_inc[k] && cnt_val[64*k +: 40] == 40'hFF_FFFF_FFFF) m_ovf[k] = 1'b1;
      if (req && we && addr == 12'h323 + k) m_sel[k] = wd[15:0];
    end
    if (req && we && addr == 12'h320) m_inh = wd & 32'h78;
    m_ev = ev;
    @(negedge clk);
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    drive(0, 0, 12'h0, 32'h0, 16'h0);
    #1;
    chk("rst_rvalid", 64'(bus.csr_rvalid_o), 64'h0);
    chk("rst_inc", 64'(cnt_inc), 64'h0);
    chk("rst_ovf", 64'(ovf), 64'h0);
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [11:0] addrs [16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    addrs = '{12'h320, 12'h323, 12'h324, 12'h325, 12'h326, 12'h327, 12'hB03, 12'hB04,
              12'hB05, 12'hB06, 12'hB83, 12'hB84, 12'hB85, 12'hB86, 12'hB07, 12'h7C0};
    cnt_val = '0;
    m_reset();
    rst_n = 1'b0;
    drive(0, 0, 12'h0, 32'h0, 16'h0);
    #1;
    chk("reset_rvalid", 64'(bus.csr_rvalid_o), 64'h0);
    chk("reset_inc", 64'(cnt_inc), 64'h0);
    chk("reset_ovf", 64'(ovf), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: read after reset, random events never increment
    step(1, 0, 12'h323, 32'h0, 16'($urandom));
    drive(0, 0, 12'h0, 32'h0, 16'($urandom));
    #1;
    chk("t1_rvalid", 64'(bus.csr_rvalid_o), 64'h1);
    chk("t1_rdata", 64'(bus.csr_rdata_o), 64'h0);
    chk("t1_err", 64'(bus.csr_err_o), 64'h0);
    repeat (4) step(0, 0, 12'h0, 32'h0, 16'($urandom));

    // 2: select event 2 on counter 3
    step(1, 1, 12'h323, 32'h4, 16'h0);
    step(0, 0, 12'h0, 32'h0, 16'h4);
    drive(0, 0, 12'h0, 32'h0, 16'h0); #1;
    chk("t2_inc", 64'(cnt_inc), 64'h1);
    step(0, 0, 12'h0, 32'h0, 16'h0);
    drive(0, 0, 12'h0, 32'h0, 16'h2); #1;
    chk("t2_once", 64'(cnt_inc), 64'h0);
    step(0, 0, 12'h0, 32'h0, 16'h2);
    drive(0, 0, 12'h0, 32'h0, 16'h0); #1;
    chk("t2_other", 64'(cnt_inc), 64'h0);

    // 3: inhibit and resume
    repeat (2) step(0, 0, 12'h0, 32'h0, 16'h4);
    step(1, 1, 12'h320, 32'h8, 16'h4);
    drive(0, 0, 12'h0, 32'h0, 16'h4); #1;
    chk("t3_inhibit", 64'(cnt_inc[0]), 64'h0);
    step(0, 0, 12'h0, 32'h0, 16'h4);
    step(1, 1, 12'h320, 32'h0, 16'h4);
    drive(0, 0, 12'h0, 32'h0, 16'h4); #1;
    chk("t3_resume", 64'(cnt_inc[0]), 64'h1);
    step(0, 0, 12'h0, 32'h0, 16'h4);

    // 4: high-half write suppresses increment
    step(1, 1, 12'h324, 32'h4, 16'h4);
    step(0, 0, 12'h0, 32'h0, 16'h4);
    drive(1, 1, 12'hB84, 32'h1234_5678, 16'h4); #1;
    chk("t4_cnth_we", 64'(cnth_we), 64'h2);
    chk("t4_cnt_we", 64'(cnt_we), 64'h0);
    chk("t4_wdata", 64'(cnt_wdata), 64'h1234_5678);
    chk("t4_inc", 64'(cnt_inc), 64'h1);
    step(1, 1, 12'hB84, 32'h1234_5678, 16'h4);

    // 5: overflow sets, sticks, and clears on a counter write
    cnt_val[39:0] = 40'hFF_FFFF_FFFF;
    step(0, 0, 12'h0, 32'h0, 16'h0);
    drive(0, 0, 12'h0, 32'h0, 16'h0); #1;
    chk("t5_ovf_set", 64'(ovf), 64'h1);
    cnt_val = '0;
    repeat (2) step(0, 0, 12'h0, 32'h0, 16'h0);
    chk("t5_ovf_sticky", 64'(ovf), 64'h1);
    step(1, 1, 12'hB03, 32'h0, 16'h0);
    drive(0, 0, 12'h0, 32'h0, 16'h0); #1;
    chk("t5_ovf_clr", 64'(ovf), 64'h0);

    // 6: unmapped read, then back-to-back reads
    step(1, 0, 12'h7C0, 32'h0, 16'h0);
    drive(0, 0, 12'h0, 32'h0, 16'h0); #1;
    chk("t6_err", 64'(bus.csr_err_o), 64'h1);
    chk("t6_rdata", 64'(bus.csr_rdata_o), 64'h0);
    step(1, 0, 12'h320, 32'h0, 16'h0);
    step(1, 0, 12'h323, 32'h0, 16'h0);
    step(1, 0, 12'h324, 32'h0, 16'h0);
    drive(0, 0, 12'h0, 32'h0, 16'h0); #1;
    chk("t6_b2b_rvalid", 64'(bus.csr_rvalid_o), 64'h1);
    chk("t6_b2b_rdata", 64'(bus.csr_rdata_o), 64'h4);

    // Random traffic with one mid-run reset
    for (int n = 0; n < 3000; n++) begin
      logic [11:0] a;
      logic [31:0] wd;
      logic [15:0] ev;
      if (n == 1500) async_reset();
      for (int k = 0; k < 4; k++)
        cnt_val[64*k +: 64] = ($urandom_range(0, 3) == 0) ?
          {24'($urandom), 40'hFF_FFFF_FFFF} : {32'($urandom), 32'($urandom)};
      a  = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 15)];
      wd = ($urandom_range(0, 1) == 0) ? ($urandom & 32'hFF) : $urandom;
      ev = 16'(1 << $urandom_range(0, 15)) | 16'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 3) == 0) ev = 16'h0;
      step(1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, a, wd, ev);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
